// File: rtl/demux_4_buf_if.sv
// Handshake bundle for demux_4_buf: one producer-side valid/ready/data/sel port
// and four consumer-side channels, each with its own valid/ready/data.
interface demux_4_buf_if #(
  parameter int BIT_WIDTH = 32,
  parameter int BIT_SEL   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic [BIT_SEL-1:0]   sel;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [BIT_WIDTH-1:0] out_data0;
  logic [BIT_WIDTH-1:0] out_data1;
  logic [BIT_WIDTH-1:0] out_data2;
  logic [BIT_WIDTH-1:0] out_data3;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux_4_buf.sv
// Registered 1-to-4 demultiplexer with a one-word buffer per channel.
// Define DEMUX_4_BYPASS_EN for zero-latency cut-through into an EMPTY channel.
module demux_4_buf #(
  parameter int BIT_WIDTH = 32,
  parameter int BIT_SEL   = 2
) (
  input  logic          clk,
  input  logic          rst,
  demux_4_buf_if.slave  bus
);

  if (BIT_SEL != 2) begin : g_bad_sel
    $error("demux_4_buf: BIT_SEL must be 2");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state  [4];
  logic [BIT_WIDTH-1:0] data_q [4];
  logic [BIT_WIDTH-1:0] word   [4];
  logic [3:0]           full;
  logic [3:0]           load;
  logic [3:0]           cut;
  logic                 accept;

  // A FULL channel may still take a word when its consumer drains it this cycle
  always_comb begin
    full = 4'b0000;
    load = 4'b0000;
    cut  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      full[i] = (state[i] == FULL);
    end
    bus.in_ready = ~rst & (~full[bus.sel] | bus.out_ready[bus.sel]);
    accept = bus.in_valid & bus.in_ready;
    for (int i = 0; i < 4; i++) begin
      load[i] = accept & (bus.sel == BIT_SEL'(i));
`ifdef DEMUX_4_BYPASS_EN
      cut[i]  = ~rst & bus.in_valid & ~full[i] & (bus.sel == BIT_SEL'(i));
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        state[i]  <= EMPTY;
        data_q[i] <= '0;
      end else begin
        if (load[i]) begin
          data_q[i] <= bus.in_data;
        end
        case (state[i])
          EMPTY: begin
`ifdef DEMUX_4_BYPASS_EN
            if (load[i] && !bus.out_ready[i]) begin
              state[i] <= FULL;
            end
`else
            if (load[i]) begin
              state[i] <= FULL;
            end
`endif
          end
          FULL: begin
            if (!load[i] && bus.out_ready[i]) begin
              state[i] <= EMPTY;
            end
          end
          default: state[i] <= EMPTY;
        endcase
      end
    end
  end

  // cut is constant zero unless cut-through is built in
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      word[i] = cut[i] ? bus.in_data : data_q[i];
    end
  end

  assign bus.out_valid = full | cut;
  assign bus.out_data0 = word[0];
  assign bus.out_data1 = word[1];
  assign bus.out_data2 = word[2];
  assign bus.out_data3 = word[3];

endmodule

// File: tb/tb_demux_4_buf.sv
// Directed self-checking bench for demux_4_buf: reset, routing, backpressure,
// back-to-back streaming, reset mid-operation and the optional cut-through path.
module tb_demux_4_buf;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_4_buf_if #(.BIT_WIDTH(32), .BIT_SEL(2)) bus ();

  demux_4_buf #(.BIT_WIDTH(32), .BIT_SEL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle's inputs just after the active edge and lets them settle
  task automatic applyStimulus(input logic valid, input logic [1:0] s,
                               input logic [31:0] data, input logic [3:0] ready);
    bus.in_valid  = valid;
    bus.sel       = s;
    bus.in_data   = data;
    bus.out_ready = ready;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chan_data(input int idx);
    case (idx)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;

    // Reset held for two edges with a valid word offered
    rst = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFF, 4'b1111);
    step();
    step();
    checkOutput("reset_valid", {28'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reset_data%0d", i), chan_data(i), 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);

    // Route one word to each channel with all consumers stalled
    for (int k = 0; k < 4; k++) begin
      w = 32'hA0A0_0000 + 32'(k);
      applyStimulus(1'b1, 2'(k), w, 4'b0000);
      checkOutput($sformatf("route_ready%0d", k), {31'd0, bus.in_ready}, 32'd1);
      step();
      applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
      checkOutput($sformatf("route_valid%0d", k), {31'd0, bus.out_valid[k]}, 32'd1);
      checkOutput($sformatf("route_data%0d", k), chan_data(k), w);
    end
    checkOutput("route_all_valid", {28'd0, bus.out_valid}, 32'h0000_000F);

    // Refill channel 2 back-to-back, then stall it
    applyStimulus(1'b1, 2'd2, 32'h1234_5678, 4'b0100);
    checkOutput("bp_refill_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 2'd2, 32'hBAD0_BAD0, 4'b0000);
      checkOutput($sformatf("bp_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
      checkOutput($sformatf("bp_data%0d", k), bus.out_data2, 32'h1234_5678);
      step();
    end
    checkOutput("bp_hold_valid", {31'd0, bus.out_valid[2]}, 32'd1);
    applyStimulus(1'b1, 2'd1, 32'h1111_2222, 4'b0010);
    checkOutput("bp_other_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("bp_other_data", bus.out_data1, 32'h1111_2222);
    checkOutput("bp_other_valid", {31'd0, bus.out_valid[1]}, 32'd1);
    checkOutput("bp_ch2_kept", bus.out_data2, 32'h1234_5678);

    // Eight consecutive words into channel 3 with every consumer ready
    for (int k = 0; k < 8; k++) begin
      w = 32'h3000_0000 + 32'(k);
      applyStimulus(1'b1, 2'd3, w, 4'b1111);
      checkOutput($sformatf("b2b_ready%0d", k), {31'd0, bus.in_ready}, 32'd1);
      step();
      checkOutput($sformatf("b2b_data%0d", k), bus.out_data3, w);
      checkOutput($sformatf("b2b_valid%0d", k), {31'd0, bus.out_valid[3]}, 32'd1);
    end
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b1111);
    step();
    checkOutput("b2b_drained", {28'd0, bus.out_valid}, 32'd0);

    // Fill channels 0 and 1, then reset for one edge
    applyStimulus(1'b1, 2'd0, 32'h5555_0000, 4'b0000);
    step();
    applyStimulus(1'b1, 2'd1, 32'h5555_0001, 4'b0000);
    step();
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("mid_filled", {28'd0, bus.out_valid}, 32'h0000_0003);
    rst = 1'b1;
    step();
    checkOutput("mid_valid", {28'd0, bus.out_valid}, 32'd0);
    checkOutput("mid_data0", bus.out_data0, 32'd0);
    checkOutput("mid_data1", bus.out_data1, 32'd0);
    checkOutput("mid_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 2'd1, 32'h6666_0001, 4'b0000);
    checkOutput("post_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("post_valid", {31'd0, bus.out_valid[1]}, 32'd1);
    checkOutput("post_data", bus.out_data1, 32'h6666_0001);

    // Word offered to EMPTY channel 0 whose consumer is ready
    applyStimulus(1'b1, 2'd0, 32'hDEAD_BEEF, 4'b0001);
`ifdef DEMUX_4_BYPASS_EN
    checkOutput("cut_valid", {31'd0, bus.out_valid[0]}, 32'd1);
    checkOutput("cut_data", bus.out_data0, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("cut_empty", {31'd0, bus.out_valid[0]}, 32'd0);
`else
    checkOutput("reg_valid_early", {31'd0, bus.out_valid[0]}, 32'd0);
    step();
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("reg_valid", {31'd0, bus.out_valid[0]}, 32'd1);
    checkOutput("reg_data", bus.out_data0, 32'hDEAD_BEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
